// File: rtl/ov9281_sccb_pkg.sv
// Shared types and constants for the OV9281 SCCB target emulator.
package ov9281_sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_RA_HI,
        ST_RA_HI_ACK,
        ST_RA_LO,
        ST_RA_LO_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_MACK,
        ST_IGNORE
    } sccb_state_e;

    localparam logic [15:0] OV9281_CHIP_ID_H_ADDR = 16'h300A;
    localparam logic [15:0] OV9281_CHIP_ID_L_ADDR = 16'h300B;
    localparam logic [7:0]  OV9281_CHIP_ID_H_VAL  = 8'h92;
    localparam logic [7:0]  OV9281_CHIP_ID_L_VAL  = 8'h81;

    localparam logic SCCB_ACK  = 1'b0;
    localparam logic SCCB_NACK = 1'b1;

endpackage

// File: rtl/sccb_bus_sync.sv
// SCL/SDA synchronizer with registered edge and START/STOP pulses (3-cycle latency).
module sccb_bus_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_sda_s,
    output logic o_start,
    output logic o_stop
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_prev;
    logic       r_sda_prev;
    logic       r_scl_rise;
    logic       r_scl_fall;
    logic       r_sda_s;
    logic       r_start;
    logic       r_stop;

    // Idle bus is high, so reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_sda_s    <= 1'b1;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
            r_scl_rise <= r_scl_sync[1] & ~r_scl_prev;
            r_scl_fall <= ~r_scl_sync[1] & r_scl_prev;
            r_sda_s    <= r_sda_sync[1];
            r_start    <= r_scl_sync[1] & r_scl_prev & r_sda_prev & ~r_sda_sync[1];
            r_stop     <= r_scl_sync[1] & r_scl_prev & ~r_sda_prev & r_sda_sync[1];
        end
    end

    assign o_scl_rise = r_scl_rise;
    assign o_scl_fall = r_scl_fall;
    assign o_sda_s    = r_sda_s;
    assign o_start    = r_start;
    assign o_stop     = r_stop;

endmodule

// File: rtl/ov9281_sccb_target.sv
// SCCB target emulating the OV9281 register interface with a write snoop port.
// Define OV9281_SCCB_ID_ROM_EN to return the fixed chip ID at 0x300A/0x300B.
module ov9281_sccb_target
    import ov9281_sccb_pkg::*;
#(
    parameter int         CLK_FREQ  = 50000000,
    parameter logic [6:0] DEV_ADDR  = 7'h60,
    parameter int         ADDR_BITS = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_scl_in,
    input  logic        i_sda_in,
    output logic        o_sda_out,
    output logic        o_sda_oe,
    output logic        o_wr_valid,
    output logic [15:0] o_wr_addr,
    output logic [7:0]  o_wr_data,
    output logic        o_busy
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // The bus must run at CLK_FREQ/40 or slower; a tiny clock cannot work.
    if (CLK_FREQ < 40) begin : g_clk_chk
        $error("CLK_FREQ too low for SCCB oversampling");
    end

    logic w_rise, w_fall, w_sda, w_start, w_stop;

    sccb_bus_sync u_sync (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_scl      (i_scl_in),
        .i_sda      (i_sda_in),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_sda_s    (w_sda),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    sccb_state_e r_state, w_state_nxt;
    logic        r_sda_oe, w_oe_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_ack_drv, w_ack_drv_nxt;

    logic [3:0]  r_bitcnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_ra_hi;
    logic        r_rw;
    logic        r_mack;
    logic [15:0] r_ptr;
    logic        r_wr_valid;
    logic [15:0] r_wr_addr;
    logic [7:0]  r_wr_data;
    logic [7:0]  r_regs [DEPTH];

    logic        w_last;
    logic [7:0]  w_byte;
    logic [15:0] w_ptr_inc;
    logic [7:0]  w_rd_cur, w_rd_nxt;
    logic        w_rom_hit;

    assign w_last    = (r_bitcnt == 4'd7);
    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_ptr_inc = r_ptr + 16'd1;

    always_comb begin
        w_rd_cur  = r_regs[r_ptr[ADDR_BITS-1:0]];
        w_rd_nxt  = r_regs[w_ptr_inc[ADDR_BITS-1:0]];
        w_rom_hit = 1'b0;
`ifdef OV9281_SCCB_ID_ROM_EN
        w_rom_hit = (r_ptr == OV9281_CHIP_ID_H_ADDR) || (r_ptr == OV9281_CHIP_ID_L_ADDR);
        if (r_ptr == OV9281_CHIP_ID_H_ADDR) w_rd_cur = OV9281_CHIP_ID_H_VAL;
        if (r_ptr == OV9281_CHIP_ID_L_ADDR) w_rd_cur = OV9281_CHIP_ID_L_VAL;
        if (w_ptr_inc == OV9281_CHIP_ID_H_ADDR) w_rd_nxt = OV9281_CHIP_ID_H_VAL;
        if (w_ptr_inc == OV9281_CHIP_ID_L_ADDR) w_rd_nxt = OV9281_CHIP_ID_L_VAL;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_ack_drv <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sda_oe  <= w_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_ack_drv <= w_ack_drv_nxt;
        end
    end

    // ACK states see two SCL falls: the first starts driving, the second releases.
    always_comb begin
        w_state_nxt   = r_state;
        w_oe_nxt      = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_ack_drv_nxt = r_ack_drv;
        if (w_stop) begin
            w_state_nxt   = ST_IDLE;
            w_oe_nxt      = 1'b0;
            w_busy_nxt    = 1'b0;
            w_ack_drv_nxt = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = ST_DEV;
            w_oe_nxt      = 1'b0;
            w_ack_drv_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_DEV: begin
                    if (w_rise && w_last) begin
                        if (w_byte[7:1] == DEV_ADDR) begin
                            w_state_nxt   = ST_DEV_ACK;
                            w_busy_nxt    = 1'b1;
                            w_ack_drv_nxt = 1'b0;
                        end else begin
                            w_state_nxt = ST_IGNORE;
                            w_busy_nxt  = 1'b0;
                        end
                    end
                end
                ST_RA_HI:  if (w_rise && w_last) w_state_nxt = ST_RA_HI_ACK;
                ST_RA_LO:  if (w_rise && w_last) w_state_nxt = ST_RA_LO_ACK;
                ST_WDATA:  if (w_rise && w_last) w_state_nxt = ST_WDATA_ACK;
                ST_DEV_ACK, ST_RA_HI_ACK, ST_RA_LO_ACK, ST_WDATA_ACK: begin
                    if (w_fall) begin
                        if (!r_ack_drv) begin
                            w_oe_nxt      = 1'b1;
                            w_ack_drv_nxt = 1'b1;
                        end else begin
                            w_oe_nxt      = 1'b0;
                            w_ack_drv_nxt = 1'b0;
                            case (r_state)
                                ST_DEV_ACK: begin
                                    if (r_rw) begin
                                        w_state_nxt = ST_RDATA;
                                        w_oe_nxt    = ~w_rd_cur[7];
                                    end else begin
                                        w_state_nxt = ST_RA_HI;
                                    end
                                end
                                ST_RA_HI_ACK: w_state_nxt = ST_RA_LO;
                                default:      w_state_nxt = ST_WDATA;
                            endcase
                        end
                    end
                end
                ST_RDATA: begin
                    if (w_fall) begin
                        if (r_bitcnt == 4'd8) begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = ST_RDATA_MACK;
                        end else begin
                            w_oe_nxt = ~r_shift[6];
                        end
                    end
                end
                ST_RDATA_MACK: begin
                    if (w_fall) begin
                        if (r_mack == SCCB_NACK) begin
                            w_state_nxt = ST_IGNORE;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_state_nxt = ST_RDATA;
                            w_oe_nxt    = ~w_rd_nxt[7];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_ra_hi    <= '0;
            r_rw       <= 1'b0;
            r_mack     <= SCCB_NACK;
            r_ptr      <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= 8'h00;
        end else begin
            r_wr_valid <= 1'b0;
            if (w_start || w_stop) begin
                r_bitcnt <= '0;
            end else begin
                case (r_state)
                    ST_DEV, ST_RA_HI, ST_RA_LO, ST_WDATA: begin
                        if (w_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= w_last ? 4'd0 : r_bitcnt + 4'd1;
                            if (w_last) begin
                                case (r_state)
                                    ST_DEV:   r_rw    <= w_byte[0];
                                    ST_RA_HI: r_ra_hi <= w_byte;
                                    ST_RA_LO: r_ptr   <= {r_ra_hi, w_byte};
                                    default: begin
                                        if (!w_rom_hit) begin
                                            r_regs[r_ptr[ADDR_BITS-1:0]] <= w_byte;
                                            r_wr_valid <= 1'b1;
                                            r_wr_addr  <= r_ptr;
                                            r_wr_data  <= w_byte;
                                        end
                                        r_ptr <= w_ptr_inc;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_DEV_ACK: begin
                        if (w_fall && r_ack_drv && r_rw) begin
                            r_shift  <= w_rd_cur;
                            r_bitcnt <= '0;
                        end
                    end
                    ST_RDATA: begin
                        if (w_rise) r_bitcnt <= r_bitcnt + 4'd1;
                        else if (w_fall && r_bitcnt != 4'd8) r_shift <= {r_shift[6:0], 1'b0};
                    end
                    ST_RDATA_MACK: begin
                        if (w_rise) begin
                            r_mack <= w_sda;
                        end else if (w_fall && r_mack == SCCB_ACK) begin
                            r_ptr    <= w_ptr_inc;
                            r_shift  <= w_rd_nxt;
                            r_bitcnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_sda_out  = 1'b0;
    assign o_sda_oe   = r_sda_oe;
    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_busy     = r_busy;

endmodule
